mips_pc_unit: RTL
=================

// Module: mips_pc_unit
// PURPOSE
//  Next-generation fetch PC unit: parametrised PC register plus next-PC select and a
//  return-address stack (RAS). hit=0 (I-cache miss) freezes all state.
//  Sits between the branch/jump resolution logic and the instruction cache address port.
//  Supplies sequential, redirect, call (jal) and return (jr $ra) next-PC selection.
// PARAMETERS
//  ADDR_W        32   PC / target width in bits
//  RESET_VECTOR  0    PC value loaded on reset
//  INSTR_BYTES   4    sequential increment; power of 2, >=1
//  RAS_DEPTH     4    return-address stack entries; power of 2, >=2
// PORTS
//  ClockPulse                 in   1       clock; all state updates on falling edge
//  Reset                      in   1       asynchronous, active-high reset
//  hit                        in   1       1 = fetch may advance; 0 = freeze everything
//  redirect_valid             in   1       taken branch / jump to target_addr
//  call_valid                 in   1       jal: push PC+INSTR_BYTES, jump to target_addr
//  ret_valid                  in   1       jr $ra: pop RAS, jump to popped address
//  target_addr                in   ADDR_W  redirect / call target
//  ret_addr                   in   ADDR_W  register-file $ra; used when RAS empty
//  CurrentInstructionAddress  out  ADDR_W  current fetch PC
//  ras_top                    out  ADDR_W  top-of-stack entry; 0 when empty
//  ras_empty                  out  1       stack holds 0 entries
//  ras_full                   out  1       stack holds RAS_DEPTH entries
//  ras_overflow               out  1       sticky: a push ever dropped an entry
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-stall):
//    PC=RESET_VECTOR, count=0, ptr=0, ras_overflow=0, ras_top=0, ras_empty=1, ras_full=0.
//  - Update only on falling edge of ClockPulse with hit=1.
//    hit=0: PC, stack and flags hold; all requests that cycle are ignored.
//  - Next-PC priority (one selected per edge):
//    redirect > call > ret > sequential.
//    SEQ:      PC <= PC+INSTR_BYTES, wraps mod 2^ADDR_W.
//    REDIRECT: PC <= target_addr; stack untouched, even if call/ret also asserted.
//    CALL:     push PC+INSTR_BYTES (wrapped); PC <= target_addr.
//    RET:      if !ras_empty, PC <= top and pop; else PC <= ret_addr, stack untouched.
//  - call_valid & ret_valid (no redirect): pop then push in the same edge.
//    Top is replaced by PC+INSTR_BYTES, count unchanged, PC <= target_addr.
//    If the stack is empty this is a plain push.
//  - Full push: circular overwrite of the oldest entry; count stays RAS_DEPTH.
//    ras_overflow set, and stays set until Reset.
//  - Pop is never performed on an empty stack.
//  - Target alignment: low log2(INSTR_BYTES) bits of target_addr/ret_addr forced to 0.
//  - Latency: next PC is combinational from the inputs and visible after the same falling edge.
//    ras_* outputs are registered state only.
// STRUCTURE
//  - Package mips_pc_pkg:
//    next_sel_t enum {SEL_SEQ, SEL_REDIRECT, SEL_CALL, SEL_RET};
//    default constants for ADDR_W, INSTR_BYTES, RESET_VECTOR.
//  - Sub-module mips_ras: circular stack (push, pop, replace; full/empty/overflow; top).
//  - Top level: next-PC mux + PC register + priority decode.
// TESTING
//  1 Reset=1 mid-run with RESET_VECTOR=0x00400000
//    -> PC=0x00400000 immediately (no clock edge); ras_empty=1, ras_overflow=0.
//  2 Sequential fetch, 3 hit=1 edges from 0x0
//    -> PC 0x4, 0x8, 0xC; hit=0 plus redirect to 0x100 for 2 edges -> PC stays 0xC.
//  3 PC=0x10, call to 0x200 -> PC=0x200, ras_top=0x14;
//    ret -> PC=0x14, ras_empty=1.
//  4 RAS_DEPTH=4, 5 calls from PCs 0x0,0x10,0x20,0x30,0x40
//    -> ras_full=1, ras_overflow=1;
//    4 rets return 0x44,0x34,0x24,0x14; 5th ret uses ret_addr.
//  5 redirect+call+ret together, target 0x300 -> PC=0x300, stack unchanged;
//    call+ret together -> top replaced, count unchanged.
//  6 PC=0xFFFFFFFC sequential -> PC=0x0;
//    redirect to 0x103 -> PC=0x100.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// Shared types and default constants for the fetch PC unit.
package mips_pc_pkg;

  // Next-PC source chosen for the current edge
  typedef enum logic [1:0] {
    SEL_SEQ      = 2'd0,
    SEL_REDIRECT = 2'd1,
    SEL_CALL     = 2'd2,
    SEL_RET      = 2'd3
  } next_sel_t;

  localparam int          DEF_ADDR_W       = 32;
  localparam int          DEF_INSTR_BYTES  = 4;
  localparam int          DEF_RAS_DEPTH    = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/mips_ras.sv
// Circular return-address stack: push, pop, or replace-top in one edge.
// A push into a full stack overwrites the oldest entry and sets a sticky
// overflow flag. Pops on an empty stack are ignored.
module mips_ras #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              overflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     ptr_q, ptr_d;      // next free slot; top lives at ptr-1
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     top_idx;

  assign top_idx    = ptr_q - 1'b1;
  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(DEPTH));
  assign overflow_o = ovf_q;
  assign top_o      = empty_o ? '0 : mem_q[top_idx];

  // Next-state: replace when push+pop hit a non-empty stack, else push or pop
  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (en_i) begin
      if (push_i && pop_i && !empty_o) begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end else if (push_i) begin
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        ptr_d  = ptr_q + 1'b1;
        if (full_o) ovf_d = 1'b1;   // oldest entry silently overwritten
        else        cnt_d = cnt_q + 1'b1;
      end else if (pop_i && !empty_o) begin
        ptr_d = ptr_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Stack state; falls with the fetch clock like the PC register
  always_ff @(negedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (wr_en) mem_q[wr_idx] <= data_i;
    end
  end

endmodule

// File: rtl/mips_pc_unit.sv
// Fetch PC unit: priority decode of redirect/call/ret, next-PC mux,
// PC register and return-address stack. hit=0 freezes everything.
module mips_pc_unit
  import mips_pc_pkg::*;
#(
  parameter int                ADDR_W       = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEF_RESET_VECTOR),
  parameter int                INSTR_BYTES  = DEF_INSTR_BYTES,
  parameter int                RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input  logic              ClockPulse,
  input  logic              Reset,
  input  logic              hit,
  input  logic              redirect_valid,
  input  logic              call_valid,
  input  logic              ret_valid,
  input  logic [ADDR_W-1:0] target_addr,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [ADDR_W-1:0] CurrentInstructionAddress,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow
);

  localparam logic [ADDR_W-1:0] INC        = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(INC - 1'b1);

  next_sel_t         sel;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pc_inc;
  logic              ras_push, ras_pop;

  assign pc_inc                    = pc_q + INC;   // wraps mod 2^ADDR_W
  assign CurrentInstructionAddress = pc_q;

  // Priority decode and stack control: redirect > call > ret > sequential
  always_comb begin
    sel      = SEL_SEQ;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (redirect_valid) begin
      sel = SEL_REDIRECT;
    end else if (call_valid) begin
      sel      = SEL_CALL;
      ras_push = 1'b1;
      ras_pop  = ret_valid && !ras_empty;   // call+ret replaces the top
    end else if (ret_valid) begin
      sel     = SEL_RET;
      ras_pop = !ras_empty;
    end
  end

  // Next-PC mux; external targets are forced onto an instruction boundary
  always_comb begin
    pc_d = pc_inc;
    unique case (sel)
      SEL_REDIRECT: pc_d = target_addr & ALIGN_MASK;
      SEL_CALL:     pc_d = target_addr & ALIGN_MASK;
      SEL_RET:      pc_d = ras_empty ? (ret_addr & ALIGN_MASK) : ras_top;
      default:      pc_d = pc_inc;
    endcase
  end

  // PC register, advances on the falling edge only when the cache hits
  always_ff @(negedge ClockPulse or posedge Reset) begin
    if (Reset)    pc_q <= RESET_VECTOR;
    else if (hit) pc_q <= pc_d;
  end

  mips_ras #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk_i      (ClockPulse),
    .rst_i      (Reset),
    .en_i       (hit),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .data_i     (pc_inc),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .full_o     (ras_full),
    .overflow_o (ras_overflow)
  );

endmodule
